uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. It accepts payload words from system logic over a valid/ready handshake and stores them in a circular FIFO. It then feeds them one at a time to the transmitter's en/busy/data interface, so producers can burst data without waiting on the line rate.

---
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO plus a launch sequencer that hands words one at a time
// to a UART transmitter over its en/busy/data interface.
module uart_tx_fifo #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PAYLOAD_BITS-1:0] in_data,
    output logic                    tx_en,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    fifo_empty,
    output logic                    fifo_full
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t                  state;
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic                    push;
    logic                    pop;

    // Full/empty come from the occupancy count so wrapped pointers never alias.
    assign fifo_empty = (fifo_count == CNT_W'(0));
    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = (state == LOAD) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Drain sequencer: tx_en is registered, so it is high exactly while in LAUNCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty && !tx_busy) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= mem[rd_ptr];
                    tx_en   <= 1'b1;
                    state   <= LAUNCH;
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: transmitter model, occupancy model and a data
// scoreboard checked every cycle, plus directed timing and reset sequences.
module tb_uart_tx_fifo;

    localparam int unsigned PW    = 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          tx_en;
    logic [PW-1:0] tx_data;
    logic          tx_busy;
    logic [4:0]    fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    uart_tx_fifo #(.PAYLOAD_BITS(PW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitter model: busy rises busy_delay cycles after en, stays busy_hold cycles.
    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    int   busy_delay = 1;
    int   busy_hold  = 20;
    int   wait_cnt   = 0;
    int   hold_cnt   = 0;
    assign tx_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        if (tx_en) begin
            if (busy_delay <= 1) begin
                model_busy <= 1'b1;
                hold_cnt   <= busy_hold;
            end else begin
                wait_cnt <= busy_delay - 1;
            end
        end else if (wait_cnt > 0) begin
            wait_cnt <= wait_cnt - 1;
            if (wait_cnt == 1) begin
                model_busy <= 1'b1;
                hold_cnt   <= busy_hold;
            end
        end else if (model_busy) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt <= 1) model_busy <= 1'b0;
        end
    end

    // Scoreboard and occupancy model: pushes judged against the bench's own count.
    logic [PW-1:0] sb[$];
    int   mcount = 0;
    logic acc_q  = 1'b0;
    logic rst_q  = 1'b0;
    logic mon_on = 1'b0;

    always @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            sb.delete();
            acc_q <= 1'b0;
        end else begin
            acc_q <= in_valid && (mcount < DEPTH);
            if (in_valid && (mcount < DEPTH)) sb.push_back(in_data);
        end
    end

    int            en_count  = 0;
    int            simul_cnt = 0;
    logic          prev_en   = 1'b0;
    logic          prev_busy = 1'b0;
    logic [PW-1:0] prev_data = '0;
    logic          stab_ok   = 1'b0;

    always @(negedge clk) begin
        logic [PW-1:0] exp_d;
        if (rst_q) begin
            mcount  = 0;
            prev_en = 1'b0;
            stab_ok = 1'b0;
        end else if (mon_on) begin
            if (acc_q && tx_en) simul_cnt++;
            mcount = mcount + (acc_q ? 1 : 0) - (tx_en ? 1 : 0);
            chk("fifo_count", 32'(fifo_count), 32'(mcount));
            chk("fifo_full", 32'(fifo_full), 32'(mcount == DEPTH));
            chk("fifo_empty", 32'(fifo_empty), 32'(mcount == 0));
            chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
            if (tx_en) begin
                en_count++;
                chk("en_while_busy", 32'(tx_busy), 32'(0));
                chk("en_consecutive", 32'(prev_en), 32'(0));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_en actual=%0h expected=none at %0t", tx_data, $time);
                end else begin
                    exp_d = sb.pop_front();
                    chk("tx_data_order", 32'(tx_data), 32'(exp_d));
                end
            end
            if (tx_busy && prev_busy && stab_ok) chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
            prev_en = tx_en;
            stab_ok = 1'b1;
        end
        prev_busy = tx_busy;
        prev_data = tx_data;
    end

    task automatic push_word(input logic [PW-1:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string nm);
        int n = 0;
        while (en_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(en_count), 32'(target));
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n = 0;
        int quiet = 0;
        while (quiet < 8 && n < budget) begin
            @(negedge clk);
            n++;
            if (fifo_empty && !tx_busy && sb.size() == 0) quiet++;
            else quiet = 0;
        end
        chk(nm, 32'(quiet >= 8), 32'(1));
    endtask

    typedef struct {
        logic [PW-1:0] data;
        logic          exp_accept;
        int            exp_count;
        logic          exp_full;
        logic          exp_ready;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int base;
        for (int i = 0; i < 17; i++) begin
            tbl[i].data       = (i < 16) ? PW'(i) : 8'hFF;
            tbl[i].exp_accept = (i < 16);
            tbl[i].exp_count  = (i < 16) ? i + 1 : 16;
            tbl[i].exp_full   = (i >= 15);
            tbl[i].exp_ready  = (i < 15);
        end

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_count", 32'(fifo_count), 32'(0));
        chk("rst_empty", 32'(fifo_empty), 32'(1));
        chk("rst_full", 32'(fifo_full), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_tx_en", 32'(tx_en), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        mon_on = 1'b1;

        // 1: single word, three-cycle launch latency
        push_word(8'hA5);
        idle_in();
        chk("t1_en_c1", 32'(tx_en), 32'(0));
        chk("t1_count_c1", 32'(fifo_count), 32'(1));
        @(negedge clk);
        chk("t1_en_c2", 32'(tx_en), 32'(0));
        @(negedge clk);
        chk("t1_en_c3", 32'(tx_en), 32'(1));
        chk("t1_tx_data", 32'(tx_data), 32'(8'hA5));
        chk("t1_count_c3", 32'(fifo_count), 32'(0));
        chk("t1_empty_c3", 32'(fifo_empty), 32'(1));
        @(negedge clk);
        chk("t1_en_c4", 32'(tx_en), 32'(0));
        wait_drain(200, "t1_drain");

        // 2: back-to-back words, busy held 20 cycles
        base = en_count;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        idle_in();
        wait_pulses(base + 3, 300, "t2_pulses");
        wait_drain(300, "t2_drain");
        chk("t2_total", 32'(en_count), 32'(base + 3));

        // 3: fill to full under a stalled transmitter, overflow word dropped
        hold_busy = 1'b1;
        base = en_count;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tbl[i].data;
            chk("t3_accept", 32'(in_ready), 32'(tbl[i].exp_accept));
            @(negedge clk);
            in_valid = 1'b0;
            chk("t3_count", 32'(fifo_count), 32'(tbl[i].exp_count));
            chk("t3_full", 32'(fifo_full), 32'(tbl[i].exp_full));
            chk("t3_ready", 32'(in_ready), 32'(tbl[i].exp_ready));
        end
        chk("t3_no_launch", 32'(en_count), 32'(base));
        hold_busy = 1'b0;
        wait_pulses(base + 16, 800, "t3_pulses");
        wait_drain(400, "t3_drain");
        chk("t3_total", 32'(en_count), 32'(base + 16));

        // 4: fill 15, drain 10, push 12 more across the pointer wrap
        busy_hold = 3;
        hold_busy = 1'b1;
        for (int i = 0; i < 15; i++) push_word(PW'(8'h40 + i));
        idle_in();
        chk("t4_count15", 32'(fifo_count), 32'(15));
        base = en_count;
        simul_cnt = 0;
        hold_busy = 1'b0;
        wait_pulses(base + 10, 400, "t4_drain10");
        chk("t4_count5", 32'(fifo_count), 32'(5));
        for (int i = 0; i < 12; i++) push_word(PW'(8'h80 + i));
        idle_in();
        wait_drain(800, "t4_drain");
        chk("t4_total", 32'(en_count), 32'(base + 27));
        chk("t4_simul_seen", 32'(simul_cnt > 0), 32'(1));

        // 5: reset during WAIT_DONE with five words queued
        busy_hold = 20;
        base = en_count;
        for (int i = 0; i < 6; i++) push_word(PW'(8'h50 + i));
        idle_in();
        wait_pulses(base + 1, 50, "t5_first");
        repeat (5) @(negedge clk);
        chk("t5_busy_pre", 32'(tx_busy), 32'(1));
        chk("t5_count_pre", 32'(fifo_count), 32'(5));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_count_post", 32'(fifo_count), 32'(0));
        chk("t5_en_post", 32'(tx_en), 32'(0));
        chk("t5_empty_post", 32'(fifo_empty), 32'(1));
        repeat (40) @(negedge clk);
        chk("t5_no_pulses", 32'(en_count), 32'(base + 1));
        push_word(8'h77);
        idle_in();
        wait_pulses(base + 2, 100, "t5_restart");
        wait_drain(200, "t5_drain");

        // 6: busy arrives four cycles after en
        busy_delay = 4;
        busy_hold  = 6;
        base = en_count;
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        idle_in();
        wait_pulses(base + 3, 300, "t6_pulses");
        wait_drain(300, "t6_drain");
        chk("t6_total", 32'(en_count), 32'(base + 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
